// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional hazard-bubble counter on o_stall_count, enabled by ID_EX_STALL_COUNT_EN.
module id_ex_reg #(
  parameter int CONTROL_SIZE  = 18,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR      = 5,
  parameter int MEM_READ_BIT  = 3,
  parameter int REG_WRITE_BIT = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_halt,
  input  logic                    i_flush,
  input  logic [CONTROL_SIZE-1:0] i_control,
  input  logic [DATA_WIDTH-1:0]   i_rs_data,
  input  logic [DATA_WIDTH-1:0]   i_rt_data,
  input  logic [DATA_WIDTH-1:0]   i_imm,
  input  logic [DATA_WIDTH-1:0]   i_pc_plus4,
  input  logic [REG_ADDR-1:0]     i_rs_addr,
  input  logic [REG_ADDR-1:0]     i_rt_addr,
  input  logic [REG_ADDR-1:0]     i_rd_addr,
  input  logic [4:0]              i_shamt,
  input  logic                    i_uses_rt,
  output logic [CONTROL_SIZE-1:0] o_control,
  output logic [DATA_WIDTH-1:0]   o_rs_data,
  output logic [DATA_WIDTH-1:0]   o_rt_data,
  output logic [DATA_WIDTH-1:0]   o_imm,
  output logic [DATA_WIDTH-1:0]   o_pc_plus4,
  output logic [REG_ADDR-1:0]     o_rs_addr,
  output logic [REG_ADDR-1:0]     o_rt_addr,
  output logic [REG_ADDR-1:0]     o_rd_addr,
  output logic [4:0]              o_shamt,
  output logic                    o_valid,
  output logic                    o_stall,
  output logic [31:0]             o_stall_count
);

  // Both control bit indices must land inside the control vector.
  if (REG_WRITE_BIT >= CONTROL_SIZE || MEM_READ_BIT >= CONTROL_SIZE) begin : g_bad_bit_index
    $error("id_ex_reg: control bit index out of range");
  end

  logic hazard;
  logic bubble;

  always_comb begin
    hazard = o_valid & o_control[MEM_READ_BIT] & (o_rt_addr != '0) &
             ((o_rt_addr == i_rs_addr) | (i_uses_rt & (o_rt_addr == i_rt_addr)));
    bubble = i_flush | hazard;
  end

  // Flush and halt both suppress the stall: flush already kills the ID slot.
  assign o_stall = hazard & ~i_flush & ~i_halt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_control  <= '0;
      o_rs_data  <= '0;
      o_rt_data  <= '0;
      o_imm      <= '0;
      o_pc_plus4 <= '0;
      o_rs_addr  <= '0;
      o_rt_addr  <= '0;
      o_rd_addr  <= '0;
      o_shamt    <= '0;
      o_valid    <= 1'b0;
    end else if (i_halt) begin
      o_valid    <= o_valid;
    end else if (bubble) begin
      o_control  <= '0;
      o_rs_data  <= '0;
      o_rt_data  <= '0;
      o_imm      <= '0;
      o_pc_plus4 <= '0;
      o_rs_addr  <= '0;
      o_rt_addr  <= '0;
      o_rd_addr  <= '0;
      o_shamt    <= '0;
      o_valid    <= 1'b0;
    end else begin
      o_control  <= i_control;
      o_rs_data  <= i_rs_data;
      o_rt_data  <= i_rt_data;
      o_imm      <= i_imm;
      o_pc_plus4 <= i_pc_plus4;
      o_rs_addr  <= i_rs_addr;
      o_rt_addr  <= i_rt_addr;
      o_rd_addr  <= i_rd_addr;
      o_shamt    <= i_shamt;
      o_valid    <= 1'b1;
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  // Counts only hazard bubbles; saturates instead of wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_count <= '0;
    end else if (o_stall && (o_stall_count != 32'hFFFF_FFFF)) begin
      o_stall_count <= o_stall_count + 32'd1;
    end
  end
`else
  assign o_stall_count = '0;
`endif

endmodule
